// File: rtl/data_mux_arbiter.sv
// data_mux_arbiter: round-robin burst arbiter/sequencer for a two-input 16-bit mux (define DATA_MUX_ARB_PRIO1_EN for fixed requester-1 priority)
module data_mux_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_0,
  input  logic [15:0] S_0,
  input  logic        last_0,
  input  logic        req_1,
  input  logic [15:0] S_1,
  input  logic        last_1,
  input  logic        out_ready,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        take_0,
  output logic        take_1,
  output logic        sel,
  output logic [15:0] Out,
  output logic        out_valid
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic slot_free, xfer_0, xfer_1, xfer, req_g, last_g, rel;
  assign gnt_0 = state == GRANT0;
  assign gnt_1 = state == GRANT1;
  assign slot_free = !out_valid || out_ready;
  assign take_0 = gnt_0 && slot_free;
  assign take_1 = gnt_1 && slot_free;
  assign xfer_0 = req_0 && take_0;
  assign xfer_1 = req_1 && take_1;
  assign xfer = xfer_0 || xfer_1;
  assign cnt_inc = cnt + 1'b1;
  assign req_g = gnt_1 ? req_1 : req_0;
  assign last_g = gnt_1 ? last_1 : last_0;
  assign rel = (take_0 || take_1) && (!req_g || last_g || cnt_inc == CNT_W'(MAX_BURST));
`ifdef DATA_MUX_ARB_PRIO1_EN
  // requester 1 wins every arbitration it takes part in
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = req_1 ? GRANT1 : req_0 ? GRANT0 : IDLE;
    else if (rel)
      state_nxt = req_1 ? GRANT1 : (gnt_1 && req_0) ? GRANT0 : IDLE;
  end
`else
  logic last_winner;
  // ties go to whoever did not own the bus last; releases hand over with no bubble
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (req_0 && req_1) ? (last_winner ? GRANT0 : GRANT1) : req_0 ? GRANT0 : req_1 ? GRANT1 : IDLE;
    else if (rel)
      state_nxt = gnt_0 ? (req_1 ? GRANT1 : IDLE) : (req_0 ? GRANT0 : IDLE);
  end
  // remember the owner of the most recently released burst
  always_ff @(posedge clk or posedge rst)
    if (rst)
      last_winner <= 1'b1;
    else if (rel)
      last_winner <= gnt_1;
`endif
  // grant state, mux select, burst count and the output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sel <= 1'b0;
      cnt <= '0;
      Out <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      sel <= state_nxt == GRANT1 ? 1'b1 : state_nxt == GRANT0 ? 1'b0 : sel;
      cnt <= rel ? '0 : xfer ? cnt_inc : cnt;
      if (xfer)
        Out <= xfer_1 ? S_1 : S_0;
      out_valid <= xfer || (out_valid && !out_ready);
    end
endmodule

// File: tb/tb_data_mux_arbiter.sv
// tb_data_mux_arbiter: randomized and directed checks of data_mux_arbiter against a bus-ownership model
module tb_data_mux_arbiter;
  localparam int MB = 8;
  logic clk = 0, rst = 1, req_0 = 0, last_0 = 0, req_1 = 0, last_1 = 0, out_ready = 0;
  logic [15:0] S_0 = '0, S_1 = '0, Out;
  logic gnt_0, gnt_1, take_0, take_1, sel, out_valid;
  logic [21:0] dut_vec;
  int checks = 0, errors = 0;
  int owner, mcnt;
  bit lw, msel, mov;
  logic [15:0] mout;

  always #5 clk = ~clk;

  data_mux_arbiter #(.MAX_BURST(MB), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_0(req_0), .S_0(S_0), .last_0(last_0),
    .req_1(req_1), .S_1(S_1), .last_1(last_1), .out_ready(out_ready),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .take_0(take_0), .take_1(take_1),
    .sel(sel), .Out(Out), .out_valid(out_valid)
  );

  assign dut_vec = {gnt_0, gnt_1, sel, out_valid, take_0, take_1, Out};

  function automatic logic [21:0] exp_vec();
    bit free;
    free = !mov || out_ready;
    return {owner == 0, owner == 1, msel, mov, owner == 0 && free, owner == 1 && free, mout};
  endfunction

  task automatic model_reset();
    owner = -1; mcnt = 0; lw = 1; msel = 0; mov = 0; mout = '0;
  endtask

  task automatic model_step();
    bit free, rq, lst, oth, xf;
    logic [15:0] d;
    free = !mov || out_ready;
    rq = owner == 1 ? req_1 : req_0;
    lst = owner == 1 ? last_1 : last_0;
    d = owner == 1 ? S_1 : S_0;
    oth = owner == 1 ? req_0 : req_1;
    xf = owner >= 0 && free && rq;
    if (xf) begin
      mout = d; mov = 1; mcnt++;
    end else if (mov && out_ready) mov = 0;
    if (owner < 0) begin
`ifdef DATA_MUX_ARB_PRIO1_EN
      owner = req_1 ? 1 : req_0 ? 0 : -1;
`else
      owner = (req_0 && req_1) ? (lw ? 0 : 1) : req_0 ? 0 : req_1 ? 1 : -1;
`endif
    end else if (free && (!rq || (xf && (lst || mcnt == MB)))) begin
      lw = owner == 1;
      mcnt = 0;
`ifdef DATA_MUX_ARB_PRIO1_EN
      owner = req_1 ? 1 : (owner == 1 && req_0) ? 0 : -1;
`else
      owner = oth ? 1 - owner : -1;
`endif
    end
    if (owner >= 0) msel = owner == 1;
  endtask

  task automatic apply(input logic r0, input logic [15:0] d0, input logic l0,
                       input logic r1, input logic [15:0] d1, input logic l1, input logic rdy);
    req_0 = r0; S_0 = d0; last_0 = l0; req_1 = r1; S_1 = d1; last_1 = l1; out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_0 = 0; req_1 = 0; last_0 = 0; last_1 = 0; out_ready = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    apply(0, 16'h0, 0, 0, 16'h0, 0, 1);
    checks++;
    if (dut_vec !== 22'd0) begin errors++; $display("FAIL reset_state: got %h expected %h", dut_vec, 22'd0); end
    tick();
    for (int i = 0; i < 6; i++) begin
      apply(1, 16'h1234, 0, 1, 16'h5678, 0, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL pre_reset_activity[%0d]: got %h expected %h", i, dut_vec, exp_vec()); end
      tick();
    end
    #3 rst = 1;
    #1;
    checks++;
    if (dut_vec !== 22'd0) begin errors++; $display("FAIL async_reset: got %h expected %h", dut_vec, 22'd0); end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      apply(0, 16'($urandom), 0, 0, 16'($urandom), 0, 1'($urandom));
      checks++;
      if ({gnt_0, gnt_1} !== 2'b00 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL idle_after_reset[%0d]: got %h expected %h", i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_single_burst();
    int beats = 0, nvalid = 0;
    bit xf;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(beats < 3, 16'd255, beats == 2, 0, 16'd0, 0, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL single_burst[%0d]: got %h expected %h", i, dut_vec, exp_vec()); end
      if (i == 1) begin
        checks++;
        if (gnt_0 !== 1'b1) begin errors++; $display("FAIL single_burst_grant_latency: got %b expected 1", gnt_0); end
      end
      if (out_valid && Out == 16'd255 && !sel) nvalid++;
      xf = owner == 0 && req_0 && (!mov || out_ready);
      tick();
      if (xf) beats++;
    end
    checks++;
    if (nvalid != 3) begin errors++; $display("FAIL single_burst_words: got %0d expected 3", nvalid); end
    apply(0, 16'd0, 0, 0, 16'd0, 0, 1);
    checks++;
    if ({gnt_0, gnt_1} !== 2'b00) begin errors++; $display("FAIL single_burst_idle: got %b expected 00", {gnt_0, gnt_1}); end
    tick();
  endtask

  task automatic test_tie();
    logic [15:0] words[$];
    logic [15:0] ew;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      apply(1, 16'd255, 0, 1, 16'd0, 0, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL tie[%0d]: got %h expected %h", i, dut_vec, exp_vec()); end
      if (i == 1) begin
        checks++;
`ifdef DATA_MUX_ARB_PRIO1_EN
        if ({gnt_0, gnt_1} !== 2'b01) begin errors++; $display("FAIL tie_first_grant: got %b expected 01", {gnt_0, gnt_1}); end
`else
        if ({gnt_0, gnt_1} !== 2'b10) begin errors++; $display("FAIL tie_first_grant: got %b expected 10", {gnt_0, gnt_1}); end
`endif
      end
      if (out_valid) words.push_back(Out);
      tick();
    end
    checks++;
    if (words.size() < 17) begin
      errors++; $display("FAIL tie_word_count: got %0d expected >=17", words.size());
    end else begin
      for (int k = 0; k < 17; k++) begin
`ifdef DATA_MUX_ARB_PRIO1_EN
        ew = 16'd0;
`else
        ew = ((k / MB) % 2 == 0) ? 16'd255 : 16'd0;
`endif
        checks++;
        if (words[k] !== ew) begin errors++; $display("FAIL tie_word[%0d]: got %0d expected %0d", k, words[k], ew); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] sb[$];
    logic [15:0] d = 16'h0100, w;
    int pushed = 0, popped = 0;
    bit xf, r;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      r = i < 20;
      apply(r, d, 0, 0, 16'd0, 0, !(i >= 4 && i < 8));
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL backpressure[%0d]: got %h expected %h", i, dut_vec, exp_vec()); end
      if (out_valid && out_ready) begin
        popped++;
        w = sb.size() > 0 ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (Out !== w) begin errors++; $display("FAIL backpressure_word[%0d]: got %h expected %h", popped, Out, w); end
      end
      xf = owner == 0 && req_0 && (!mov || out_ready);
      if (xf) begin sb.push_back(S_0); pushed++; end
      tick();
      if (xf) d++;
    end
    checks++;
    if (pushed != popped || sb.size() != 0) begin
      errors++; $display("FAIL backpressure_conservation: got %0d words out expected %0d", popped, pushed);
    end
  endtask

  task automatic test_early_idle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(i > 0, 16'hAAAA, 0, i < 3, 16'h5555, 0, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL early_idle[%0d]: got %h expected %h", i, dut_vec, exp_vec()); end
      if (i == 4) begin
        checks++;
        if ({gnt_0, gnt_1, sel} !== 3'b100) begin errors++; $display("FAIL early_idle_switch: got %b expected 100", {gnt_0, gnt_1, sel}); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit hold_0 = 0, hold_1 = 0, r0 = 0, r1 = 0, l0 = 0, l1 = 0, rdy;
    logic [15:0] d0 = '0, d1 = '0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (!hold_0) begin r0 = $urandom_range(0, 9) < 7; d0 = 16'($urandom); l0 = $urandom_range(0, 5) == 0; end
      if (!hold_1) begin r1 = $urandom_range(0, 9) < 7; d1 = 16'($urandom); l1 = $urandom_range(0, 5) == 0; end
      rdy = $urandom_range(0, 3) != 0;
      apply(r0, d0, l0, r1, d1, l1, rdy);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec()); end
      hold_0 = r0 && !(owner == 0 && (!mov || rdy));
      hold_1 = r1 && !(owner == 1 && (!mov || rdy));
      tick();
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_single_burst();
    test_tie();
    test_backpressure();
    test_early_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mux_arbiter.md
Name: data_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the 16-bit two-input Data_MUX datapath.
- Shares one 16-bit output bus between requester 0 (S_0) and requester 1 (S_1) in bursts.
- Drives the mux select, registers the muxed word, and presents it downstream with a valid/ready handshake.
- Sits between two data producers and a single 16-bit consumer.

Parameters:
- MAX_BURST, 8, max beats per grant before forced re-arbitration; legal range 1..255.
- CNT_W, 8, burst counter width; must hold MAX_BURST.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_0  input  1  requester 0 has a beat on S_0
- S_0  input  16  requester 0 data
- last_0  input  1  beat on S_0 is the final beat of its burst
- req_1  input  1  requester 1 has a beat on S_1
- S_1  input  16  requester 1 data
- last_1  input  1  beat on S_1 is the final beat of its burst
- out_ready  input  1  consumer accepts Out this cycle
- gnt_0  output  1  requester 0 owns the bus (registered)
- gnt_1  output  1  requester 1 owns the bus (registered)
- take_0  output  1  beat on S_0 is consumed this cycle (combinational)
- take_1  output  1  beat on S_1 is consumed this cycle (combinational)
- sel  output  1  mux select: 1 = S_1, 0 = S_0 (registered)
- Out  output  16  registered output word
- out_valid  output  1  Out holds an unconsumed word

Behaviour:
- Reset (async, immediate):
  - state = IDLE; gnt_0 = gnt_1 = sel = out_valid = 0; Out = 16'd0; burst count = 0.
  - last_winner = 1, so requester 0 wins the first tie.
- States are IDLE, GRANT0, GRANT1. Encoding:
  - gnt_0 = (state == GRANT0); gnt_1 = (state == GRANT1).
  - sel = 1 only in GRANT1. In IDLE, sel holds its last value.
- IDLE:
  - Only req_0 high → GRANT0. Only req_1 high → GRANT1.
  - Both high → grant the requester that is not last_winner.
  - Neither high → stay in IDLE.
  - The grant becomes visible on the next edge; there is no data transfer in the arbitration cycle.
- Slot free = !out_valid || out_ready.
- take_x = gnt_x && slot_free; take_x is never high for the ungranted side.
- Beat transfer = req_x && take_x. On a transfer:
  - Out <= S_x and out_valid <= 1.
  - Burst count increments.
- Output drain: out_valid && out_ready with no transfer that cycle → out_valid <= 0.
- A simultaneous drain and transfer is back-to-back: out_valid stays 1. Sustained throughput is 1 word/cycle.
- out_valid && !out_ready: Out and out_valid hold, take_x = 0, and the burst stalls without releasing.
- Release from GRANTx, evaluated at the edge:
  - Release condition is any of:
    - a transfer with last_x = 1;
    - a transfer that makes the count equal MAX_BURST;
    - req_x = 0 while take_x = 1 (requester went idle).
  - On release:
    - last_winner <= x and count <= 0.
    - If the other requester's req is high → go directly to GRANT(other). Switch cost is 0 bubble cycles; the grant changes on the same edge.
    - Otherwise → IDLE.
- MAX_BURST = 1: every transfer releases the grant, giving strict alternation when both requesters are active.
- Counter never wraps, because release occurs at MAX_BURST.
- Reset mid-burst: all state is cleared and any in-flight Out word is discarded. Requesters must re-request.
- Requester data and last must remain stable while req_x = 1 and take_x = 0.

Optional Feature:
- Macro: DATA_MUX_ARB_PRIO1_EN.
- Defined:
  - Requester 1 has fixed priority. In IDLE, or at a release with both requesting, GRANT1 is chosen.
  - The MAX_BURST limit still forces GRANT0 to release.
  - last_winner is ignored.
- Undefined: round-robin exactly as above.

Test Plan:
- Reset then idle: rst=1 mid-run → all outputs 0 immediately, Out=16'd0. With no req for 10 cycles, state stays IDLE and gnt_0=gnt_1=0.
- Single burst: req_0=1, S_0=16'd255, last_0 on beat 3, out_ready=1. Expected:
  - gnt_0 rises 1 cycle after req_0.
  - 3 consecutive out_valid beats with Out=255 and sel=0.
  - Then IDLE.
- Tie and alternation: req_0 = req_1 = 1 from reset, S_0=16'd255, S_1=16'd0, MAX_BURST=8, no last. Expected:
  - Requester 0 gets 8 beats, then GRANT1 with sel=1 and 8 beats of Out=0, then back to requester 0.
- Backpressure: during a burst, drop out_ready for 4 cycles. Expected:
  - Out and out_valid held; take_0 = 0; the count does not advance and no words are lost or duplicated.
- Early idle: requester 1 granted, req_1 drops after 2 beats while req_0=1 → next edge gnt_1=0, gnt_0=1, sel=0.
- With DATA_MUX_ARB_PRIO1_EN defined and both requesting from reset → GRANT1 is first. Run once with the macro and once without.
